// File: rtl/button_event_fsm.sv
// Classifies debounced button gestures into short / long / double-click pulses.
// Optional auto-repeat while long-held is enabled with `define BUTTON_AUTO_REPEAT_EN.
module button_event_fsm #(
    parameter int CNT_W    = 26,
    parameter int LONG_CYC = 25_000_000,
    parameter int DBL_CYC  = 12_500_000,
    parameter int RPT_CYC  = 5_000_000
) (
    input  logic i_clk,
    input  logic i_nrst,
    input  logic i_db_level,
    input  logic i_db_tick,
    output logic o_short,
    output logic o_long,
    output logic o_double,
    output logic o_repeat,
    output logic o_busy
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESS1    = 3'd1,
        WAIT_DBL  = 3'd2,
        PRESS2    = 3'd3,
        HOLD_LONG = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_CYC - 1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic             cnt_run;
    logic             short_nx, long_nx, double_nx, repeat_nx;

    always_comb begin
        state_nx  = state;
        cnt_run   = 1'b0;
        short_nx  = 1'b0;
        long_nx   = 1'b0;
        double_nx = 1'b0;
        repeat_nx = 1'b0;
        case (state)
            IDLE: begin
                if (i_db_tick) state_nx = PRESS1;
            end
            PRESS1: begin
                cnt_run = 1'b1;
                // release takes priority over a coincident long compare
                if (!i_db_level) begin
                    state_nx = WAIT_DBL;
                end else if (cnt == LONG_LAST) begin
                    state_nx = HOLD_LONG;
                    long_nx  = 1'b1;
                end
            end
            WAIT_DBL: begin
                cnt_run = 1'b1;
                if (i_db_tick) begin
                    state_nx = PRESS2;
                end else if (cnt == DBL_LAST) begin
                    state_nx = IDLE;
                    short_nx = 1'b1;
                end
            end
            PRESS2: begin
                if (!i_db_level) begin
                    state_nx  = IDLE;
                    double_nx = 1'b1;
                end
            end
            HOLD_LONG: begin
`ifdef BUTTON_AUTO_REPEAT_EN
                cnt_run = 1'b1;
                if (!i_db_level) begin
                    state_nx = IDLE;
                end else if (cnt == CNT_W'(RPT_CYC - 1)) begin
                    repeat_nx = 1'b1;
                end
`else
                if (!i_db_level) state_nx = IDLE;
`endif
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state    <= IDLE;
            cnt      <= '0;
            o_short  <= 1'b0;
            o_long   <= 1'b0;
            o_double <= 1'b0;
            o_repeat <= 1'b0;
            o_busy   <= 1'b0;
        end else begin
            state    <= state_nx;
            // counter only runs in states with a terminal compare, so it never wraps
            if (state_nx != state || repeat_nx || !cnt_run) cnt <= '0;
            else                                             cnt <= cnt + 1'b1;
            o_short  <= short_nx;
            o_long   <= long_nx;
            o_double <= double_nx;
            o_repeat <= repeat_nx;
            o_busy   <= (state_nx != IDLE);
        end
    end

endmodule

// File: tb/tb_button_event_fsm.sv
// Directed-vector bench for button_event_fsm with a timestamp-based gesture model.
module tb_button_event_fsm;
    localparam int CW = 4, LC = 8, DC = 6, RC = 4;
`ifdef BUTTON_AUTO_REPEAT_EN
    localparam int REP = 1;
`else
    localparam int REP = 0;
`endif

    logic clk = 0, nrst = 0, lvl = 0, tick = 0;
    logic o_short, o_long, o_double, o_repeat, o_busy;
    int vectors = 0, errors = 0;

    button_event_fsm #(.CNT_W(CW), .LONG_CYC(LC), .DBL_CYC(DC), .RPT_CYC(RC)) dut (
        .i_clk(clk), .i_nrst(nrst), .i_db_level(lvl), .i_db_tick(tick),
        .o_short(o_short), .o_long(o_long), .o_double(o_double),
        .o_repeat(o_repeat), .o_busy(o_busy));

    always #5 clk = ~clk;

    // model: phase 0 idle, 1 first press, 2 released, 3 second press, 4 long hold
    int ph = 0, t0 = 0;
    bit m_s, m_l, m_d, m_r;
    int d_at[4], d_cnt[4], m_at[4];

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_step(input int k, input bit l, input bit tk, input bit nr);
        {m_s, m_l, m_d, m_r} = '0;
        if (!nr) ph = 0;
        else case (ph)
            0: if (tk) begin ph = 1; t0 = k; end
            1: if (!l) begin ph = 2; t0 = k; end
               else if (k - t0 == LC) begin ph = 4; t0 = k; m_l = 1; end
            2: if (tk) ph = 3;
               else if (k - t0 == DC) begin ph = 0; m_s = 1; end
            3: if (!l) begin ph = 0; m_d = 1; end
            default: if (!l) ph = 0;
                     else if (REP == 1 && k - t0 == RC) begin t0 = k; m_r = 1; end
        endcase
    endtask

    task automatic run_scn(input string nm, input int t1, r1, t2, r2, ra, rb,
                           input int e_s, e_l, e_d, e_r_at, e_r_cnt);
        bit [3:0] dv, mv;
        for (int i = 0; i < 4; i++) begin d_at[i] = -1; d_cnt[i] = 0; m_at[i] = -1; end
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            lvl  = (c >= t1 && c < r1) || (t2 >= 0 && c >= t2 && c < r2);
            tick = (c == t1) || (c == t2);
            nrst = !(c >= ra && c <= rb);
            @(posedge clk);
            model_step(c, lvl, tick, nrst);
            #1;
            dv = {o_repeat, o_double, o_long, o_short};
            mv = {m_r, m_d, m_l, m_s};
            check($sformatf("%s cyc%0d pulses", nm, c + 1), int'(dv), int'(mv));
            check($sformatf("%s cyc%0d busy", nm, c + 1), int'(o_busy), int'(ph != 0));
            for (int i = 0; i < 4; i++) begin
                if (dv[i]) begin d_cnt[i]++; if (d_at[i] < 0) d_at[i] = c + 1; end
                if (mv[i] && m_at[i] < 0) m_at[i] = c + 1;
            end
        end
        check({nm, " short_at"},  d_at[0], e_s);
        check({nm, " long_at"},   d_at[1], e_l);
        check({nm, " double_at"}, d_at[2], e_d);
        check({nm, " repeat_at"}, d_at[3], e_r_at);
        check({nm, " short_cnt"},  d_cnt[0], (e_s >= 0) ? 1 : 0);
        check({nm, " long_cnt"},   d_cnt[1], (e_l >= 0) ? 1 : 0);
        check({nm, " double_cnt"}, d_cnt[2], (e_d >= 0) ? 1 : 0);
        check({nm, " repeat_cnt"}, d_cnt[3], e_r_cnt);
        check({nm, " model_short_at"},  m_at[0], e_s);
        check({nm, " model_long_at"},   m_at[1], e_l);
        check({nm, " model_double_at"}, m_at[2], e_d);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset outputs", int'({o_short, o_long, o_double, o_repeat, o_busy}), 0);
        @(negedge clk);
        nrst = 1;
        //           name      t1  r1  t2  r2  ra  rb  short long dbl rep_at          rep_cnt
        run_scn("short",   10, 13, -1, -1, -1, -1, 20, -1, -1, -1,                   0);
        run_scn("long",    10, 30, -1, -1, -1, -1, -1, 19, -1, (REP == 1) ? 23 : -1, 2 * REP);
        run_scn("double",  10, 12, 15, 17, -1, -1, -1, -1, 18, -1,                   0);
        run_scn("race_rel",10, 18, -1, -1, -1, -1, 25, -1, -1, -1,                   0);
        run_scn("race_tck",10, 12, 18, 20, -1, -1, -1, -1, 21, -1,                   0);
        run_scn("reset",   10, 20, 25, 28, 14, 15, 35, -1, -1, -1,                   0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
